// File: rtl/pad_ring_pkg.sv
// Shared types for the pad ring controller: FSM states, pad attributes and park code.
// No logic; latency and backpressure are defined by the modules that import it.
package pad_ring_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_GUARD,
        ST_COMMIT
    } state_e;

    typedef struct packed {
        logic pu;
        logic pd;
        logic cs;
        logic sl;
    } attr_t;

    localparam attr_t ATTR_RST = '{pu: 1'b0, pd: 1'b1, cs: 1'b0, sl: 1'b0};

    localparam int SEL_PARK = 0;

    // Enabling pull-up and pull-down together would fight on the pad.
    function automatic logic attr_legal(attr_t a);
        return !(a.pu && a.pd);
    endfunction

endpackage

// File: rtl/pad_ring_ctrl_if.sv
// Config port and pad/function buses of the pad ring controller.
// slave = controller side, master = chip core / pad side.
interface pad_ring_ctrl_if
    import pad_ring_pkg::*;
#(
    parameter int NUM_BIDIR = 54,
    parameter int NUM_FUNC  = 4
);
    localparam int PW  = $clog2(NUM_BIDIR);
    localparam int FW  = $clog2(NUM_FUNC + 1);
    localparam int NFB = NUM_FUNC * NUM_BIDIR;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [PW-1:0]   cfg_pad;
    logic [FW-1:0]   cfg_func;
    attr_t           cfg_attr;
    logic            cfg_err;
    logic            ring_ready;

    logic [NFB-1:0]  func_out;
    logic [NFB-1:0]  func_oe;
    logic [NFB-1:0]  func_in;

    logic [NUM_BIDIR-1:0] pad_in;
    logic [NUM_BIDIR-1:0] pad_out;
    logic [NUM_BIDIR-1:0] pad_oe;
    logic [NUM_BIDIR-1:0] pad_cs;
    logic [NUM_BIDIR-1:0] pad_sl;
    logic [NUM_BIDIR-1:0] pad_ie;
    logic [NUM_BIDIR-1:0] pad_pu;
    logic [NUM_BIDIR-1:0] pad_pd;

    modport master (
        output cfg_valid, cfg_pad, cfg_func, cfg_attr,
        output func_out, func_oe, pad_in,
        input  cfg_ready, cfg_err, ring_ready, func_in,
        input  pad_out, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd
    );

    modport slave (
        input  cfg_valid, cfg_pad, cfg_func, cfg_attr,
        input  func_out, func_oe, pad_in,
        output cfg_ready, cfg_err, ring_ready, func_in,
        output pad_out, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd
    );

endinterface

// File: rtl/pad_mux_slice.sv
// Per-pad function mux: routes the selected function to the pad and the pad input back.
// Purely combinational (zero cycles); no backpressure.
module pad_mux_slice
    import pad_ring_pkg::*;
#(
    parameter int NUM_FUNC = 4,
    parameter int FW       = 3
) (
    input  logic [FW-1:0]       sel,
    input  logic                guard,
    input  logic                settle,
    input  logic [NUM_FUNC-1:0] func_out,
    input  logic [NUM_FUNC-1:0] func_oe,
    input  logic                pad_in,
    output logic [NUM_FUNC-1:0] func_in,
    output logic                pad_out,
    output logic                pad_oe,
    output logic                pad_ie
);

    always_comb begin
        pad_out = 1'b0;
        pad_oe  = 1'b0;
        pad_ie  = 1'b0;
        func_in = '0;
        // Codes above NUM_FUNC never reach the register, so they fall through as parked.
        if (!settle && !guard && sel != FW'(SEL_PARK)) begin
            for (int f = 0; f < NUM_FUNC; f++) begin
                if (sel == FW'(f + 1)) begin
                    pad_out    = func_out[f];
                    pad_oe     = func_oe[f];
                    pad_ie     = 1'b1;
                    func_in[f] = pad_in;
                end
            end
        end
    end

endmodule

// File: rtl/pad_ring_ctrl.sv
// Pad ring function/attribute controller with post-reset settle and parked guard on function change.
// Data path 0 cycles; config accepted only in IDLE (cfg_ready), one write in flight, bad writes pulse cfg_err.
module pad_ring_ctrl
    import pad_ring_pkg::*;
#(
    parameter int NUM_BIDIR     = 54,
    parameter int NUM_FUNC      = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int GUARD_CYCLES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    pad_ring_ctrl_if.slave  bus
);

    localparam int PW   = $clog2(NUM_BIDIR);
    localparam int FW   = $clog2(NUM_FUNC + 1);
    localparam int CMAX = (SETTLE_CYCLES > GUARD_CYCLES) ? SETTLE_CYCLES : GUARD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_e                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            ring_ready_q;
    logic                            err_q;

    logic [NUM_BIDIR-1:0][FW-1:0]    sel_q;
    attr_t [NUM_BIDIR-1:0]           attr_q;
    logic [NUM_BIDIR-1:0]            guard_q;

    logic [PW-1:0]                   wr_pad_q;
    logic [FW-1:0]                   wr_func_q;
    attr_t                           wr_attr_q;

    logic                            req_ok;
    logic                            take_attr;
    logic                            take_chg;
    logic                            reject;
    logic                            commit;
    logic                            settle_done;
    logic                            settle;

    assign req_ok = (int'(bus.cfg_pad) < NUM_BIDIR) &&
                    (int'(bus.cfg_func) <= NUM_FUNC) &&
                    attr_legal(bus.cfg_attr);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        take_attr   = 1'b0;
        take_chg    = 1'b0;
        reject      = 1'b0;
        commit      = 1'b0;
        settle_done = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (int'(cnt_q) == SETTLE_CYCLES - 1) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    settle_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    if (!req_ok) begin
                        reject = 1'b1;
                    end else if (bus.cfg_func == sel_q[bus.cfg_pad]) begin
                        // Same function: attributes only, no parking gap needed.
                        take_attr = 1'b1;
                        state_d   = ST_COMMIT;
                    end else begin
                        take_chg = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (int'(cnt_q) == GUARD_CYCLES - 1) begin
                    state_d = ST_COMMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SETTLE;
            cnt_q        <= '0;
            ring_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ring_ready_q <= ring_ready_q | settle_done;
            err_q        <= reject;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BIDIR; i++) begin
                sel_q[i]  <= FW'(SEL_PARK);
                attr_q[i] <= ATTR_RST;
            end
            guard_q   <= '0;
            wr_pad_q  <= '0;
            wr_func_q <= '0;
            wr_attr_q <= ATTR_RST;
        end else begin
            if (take_attr || take_chg) begin
                wr_pad_q  <= bus.cfg_pad;
                wr_func_q <= bus.cfg_func;
                wr_attr_q <= bus.cfg_attr;
            end
            if (take_chg) begin
                guard_q[bus.cfg_pad] <= 1'b1;
            end
            if (commit) begin
                sel_q[wr_pad_q]   <= wr_func_q;
                attr_q[wr_pad_q]  <= wr_attr_q;
                guard_q[wr_pad_q] <= 1'b0;
            end
        end
    end

    assign settle         = (state_q == ST_SETTLE);
    assign bus.cfg_ready  = (state_q == ST_IDLE);
    assign bus.cfg_err    = err_q;
    assign bus.ring_ready = ring_ready_q;

    // Function-major views of the flat buses: bit [f][i] == flat bit f*NUM_BIDIR+i.
    logic [NUM_FUNC-1:0][NUM_BIDIR-1:0] fo_fm;
    logic [NUM_FUNC-1:0][NUM_BIDIR-1:0] foe_fm;
    logic [NUM_FUNC-1:0][NUM_BIDIR-1:0] fi_fm;

    assign fo_fm       = bus.func_out;
    assign foe_fm      = bus.func_oe;
    assign bus.func_in = fi_fm;

    for (genvar i = 0; i < NUM_BIDIR; i++) begin : g_pad
        logic [NUM_FUNC-1:0] fo;
        logic [NUM_FUNC-1:0] foe;
        logic [NUM_FUNC-1:0] fi;

        for (genvar f = 0; f < NUM_FUNC; f++) begin : g_fn
            assign fo[f]       = fo_fm[f][i];
            assign foe[f]      = foe_fm[f][i];
            assign fi_fm[f][i] = fi[f];
        end

        pad_mux_slice #(
            .NUM_FUNC (NUM_FUNC),
            .FW       (FW)
        ) u_slice (
            .sel      (sel_q[i]),
            .guard    (guard_q[i]),
            .settle   (settle),
            .func_out (fo),
            .func_oe  (foe),
            .pad_in   (bus.pad_in[i]),
            .func_in  (fi),
            .pad_out  (bus.pad_out[i]),
            .pad_oe   (bus.pad_oe[i]),
            .pad_ie   (bus.pad_ie[i])
        );

        assign bus.pad_pu[i] = attr_q[i].pu;
        assign bus.pad_pd[i] = attr_q[i].pd;
        assign bus.pad_cs[i] = attr_q[i].cs;
        assign bus.pad_sl[i] = attr_q[i].sl;
    end

endmodule

// File: tb/tb_pad_ring_ctrl.sv
// Bench for pad_ring_ctrl: directed test-plan steps plus random config traffic,
// all outputs compared every cycle against a timestamp-based reference model.
module tb_pad_ring_ctrl;
    import pad_ring_pkg::*;

    localparam int NB     = 54;
    localparam int NF     = 4;
    localparam int SETTLE = 16;
    localparam int GUARD  = 4;
    localparam int NFB    = NB * NF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pad_ring_ctrl_if #(.NUM_BIDIR(NB), .NUM_FUNC(NF)) bus ();

    pad_ring_ctrl #(
        .NUM_BIDIR     (NB),
        .NUM_FUNC      (NF),
        .SETTLE_CYCLES (SETTLE),
        .GUARD_CYCLES  (GUARD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cycle index since reset release, committed pad state,
    // and the single pending write with the cycle at which it becomes visible.
    bit         known = 1'b0;
    int         cyc;
    int         m_sel  [NB];
    logic [3:0] m_attr [NB];
    bit         pend;
    bit         pend_chg;
    int         pend_pad, pend_func, pend_apply;
    logic [3:0] pend_attr;
    int         busy_until;
    int         err_at;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < NB; i++) begin
            m_sel[i]  = 0;
            m_attr[i] = 4'b0100;
        end
        pend       = 1'b0;
        busy_until = 0;
        err_at     = -1;
    endtask

    task automatic check_model();
        logic [NB-1:0]  e_out, e_oe, e_ie, e_pu, e_pd, e_cs, e_sl;
        logic [NFB-1:0] e_fi;
        bit             settle_m;
        bit             parked;
        int             s;
        settle_m = (cyc < SETTLE);
        e_out = '0; e_oe = '0; e_ie = '0; e_fi = '0;
        for (int i = 0; i < NB; i++) begin
            e_pu[i] = m_attr[i][3];
            e_pd[i] = m_attr[i][2];
            e_cs[i] = m_attr[i][1];
            e_sl[i] = m_attr[i][0];
            parked = settle_m || (m_sel[i] == 0) || (pend && pend_chg && pend_pad == i);
            if (!parked) begin
                s = (m_sel[i] - 1) * NB + i;
                e_out[i] = bus.func_out[s];
                e_oe[i]  = bus.func_oe[s];
                e_ie[i]  = 1'b1;
                e_fi[s]  = bus.pad_in[i];
            end
        end
        chk("ring_ready", 256'(bus.ring_ready), 256'(!settle_m));
        chk("cfg_ready",  256'(bus.cfg_ready),  256'(!settle_m && cyc >= busy_until));
        chk("cfg_err",    256'(bus.cfg_err),    256'(cyc == err_at));
        chk("pad_out",    256'(bus.pad_out),    256'(e_out));
        chk("pad_oe",     256'(bus.pad_oe),     256'(e_oe));
        chk("pad_ie",     256'(bus.pad_ie),     256'(e_ie));
        chk("pad_pu",     256'(bus.pad_pu),     256'(e_pu));
        chk("pad_pd",     256'(bus.pad_pd),     256'(e_pd));
        chk("pad_cs",     256'(bus.pad_cs),     256'(e_cs));
        chk("pad_sl",     256'(bus.pad_sl),     256'(e_sl));
        chk("func_in",    256'(bus.func_in),    256'(e_fi));
    endtask

    task automatic model_step();
        int         p, f;
        logic [3:0] a;
        if (rst) begin
            model_reset();
            known = 1'b1;
        end else if (known) begin
            if (bus.cfg_valid && cyc >= SETTLE && cyc >= busy_until) begin
                p = int'(bus.cfg_pad);
                f = int'(bus.cfg_func);
                a = bus.cfg_attr;
                if (p >= NB || f > NF || (a[3] && a[2])) begin
                    err_at = cyc + 1;
                end else begin
                    pend       = 1'b1;
                    pend_pad   = p;
                    pend_func  = f;
                    pend_attr  = a;
                    pend_chg   = (f != m_sel[p]);
                    pend_apply = cyc + (pend_chg ? 2 + GUARD : 2);
                    busy_until = pend_apply;
                end
            end
            cyc++;
            if (pend && cyc == pend_apply) begin
                m_sel[pend_pad]  = pend_func;
                m_attr[pend_pad] = pend_attr;
                pend = 1'b0;
            end
        end
    endtask

    task automatic drive_data();
        logic [223:0] a, b;
        logic [63:0]  c;
        for (int w = 0; w < 7; w++) begin
            a[w*32 +: 32] = $urandom;
            b[w*32 +: 32] = $urandom;
        end
        c = {$urandom, $urandom};
        bus.func_out = a[NFB-1:0];
        bus.func_oe  = b[NFB-1:0];
        bus.pad_in   = c[NB-1:0];
    endtask

    task automatic mid();
        @(negedge clk);
        if (known) check_model();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        mid();
        adv();
    endtask

    task automatic set_cfg(input int p, input int f, input logic [3:0] a);
        bus.cfg_valid = 1'b1;
        bus.cfg_pad   = 6'(p);
        bus.cfg_func  = 3'(f);
        bus.cfg_attr  = a;
    endtask

    // Starts at cycle 0 after release; counts cycles until cfg_ready rises.
    task automatic measure_settle(input string tag);
        int n;
        n = -1;
        for (int k = 0; k < 40; k++) begin
            drive_data();
            mid();
            if (k == 0) begin
                chk({tag, "_oe"},  256'(bus.pad_oe),     256'(0));
                chk({tag, "_ie"},  256'(bus.pad_ie),     256'(0));
                chk({tag, "_pd"},  256'(bus.pad_pd),     256'({NB{1'b1}}));
                chk({tag, "_pu"},  256'(bus.pad_pu),     256'(0));
                chk({tag, "_rdy"}, 256'(bus.ring_ready), 256'(0));
            end
            if (bus.cfg_ready && n < 0) n = k;
            adv();
            if (n >= 0) break;
        end
        chk({tag, "_settle_len"}, 256'(n), 256'(SETTLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f7;
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_pad   = '0;
        bus.cfg_func  = '0;
        bus.cfg_attr  = 4'b0000;
        drive_data();
        repeat (3) tick();
        rst = 1'b0;
        measure_settle("reset");

        // Function change: pad 3 -> function 2 (code 2 = func index 1).
        drive_data(); bus.func_oe[57] = 1'b1; bus.func_out[57] = 1'b1;
        set_cfg(3, 2, 4'b0100);
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive_data(); bus.func_oe[57] = 1'b1; bus.func_out[57] = 1'b1;
            mid();
            if (k <= GUARD + 1) begin
                chk("chg_park_oe", 256'(bus.pad_oe[3]),   256'(0));
                chk("chg_busy",    256'(bus.cfg_ready),   256'(0));
            end else begin
                chk("chg_drive_oe",  256'(bus.pad_oe[3]),   256'(1));
                chk("chg_drive_out", 256'(bus.pad_out[3]),  256'(1));
                chk("chg_func_in",   256'(bus.func_in[57]), 256'(bus.pad_in[3]));
                chk("chg_ready",     256'(bus.cfg_ready),   256'(1));
            end
            adv();
        end

        // Switch pad 3 from function 2 to function 1 with both functions driving.
        drive_data();
        bus.func_oe[57] = 1'b1; bus.func_oe[3] = 1'b1; bus.func_out[3] = 1'b1; bus.pad_in[3] = 1'b1;
        set_cfg(3, 1, 4'b0100);
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive_data();
            bus.func_oe[57] = 1'b1; bus.func_oe[3] = 1'b1; bus.func_out[3] = 1'b1; bus.pad_in[3] = 1'b1;
            mid();
            if (k <= GUARD + 1) begin
                chk("sw_park_oe",  256'(bus.pad_oe[3]),   256'(0));
                chk("sw_old_fi",   256'(bus.func_in[57]), 256'(0));
                chk("sw_new_fi",   256'(bus.func_in[3]),  256'(0));
            end else begin
                chk("sw_drive_oe", 256'(bus.pad_oe[3]),  256'(1));
                chk("sw_drive_out",256'(bus.pad_out[3]), 256'(1));
                chk("sw_new_fi",   256'(bus.func_in[3]), 256'(1));
            end
            adv();
        end

        // Attribute-only write: pu=1, pd=0 on pad 3, same function.
        drive_data(); bus.func_oe[3] = 1'b1;
        set_cfg(3, 1, 4'b1000);
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            drive_data(); bus.func_oe[3] = 1'b1;
            mid();
            chk("attr_oe_held", 256'(bus.pad_oe[3]), 256'(1));
            chk("attr_pu", 256'(bus.pad_pu[3]), 256'(k == 2));
            chk("attr_pd", 256'(bus.pad_pd[3]), 256'(k != 2));
            adv();
        end

        // Rejected writes: bad pad, bad function, pu and pd together.
        for (int r = 0; r < 3; r++) begin
            drive_data(); bus.func_oe[3] = 1'b1;
            case (r)
                0:       set_cfg(54, 1, 4'b0100);
                1:       set_cfg(3,  5, 4'b0100);
                default: set_cfg(3,  1, 4'b1100);
            endcase
            tick();
            bus.cfg_valid = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                drive_data(); bus.func_oe[3] = 1'b1;
                mid();
                chk("rej_err",   256'(bus.cfg_err),    256'(k == 1));
                chk("rej_ready", 256'(bus.cfg_ready),  256'(1));
                chk("rej_pu",    256'(bus.pad_pu[3]),  256'(1));
                chk("rej_oe",    256'(bus.pad_oe[3]),  256'(1));
                adv();
            end
        end

        // Random configuration traffic.
        for (int n = 0; n < 400; n++) begin
            drive_data();
            bus.cfg_valid = 1'($urandom_range(0, 1));
            bus.cfg_pad   = 6'($urandom_range(0, 57));
            bus.cfg_func  = 3'($urandom_range(0, 5));
            bus.cfg_attr  = 4'($urandom_range(0, 15));
            tick();
        end
        bus.cfg_valid = 1'b0;
        repeat (8) begin
            drive_data();
            tick();
        end

        // Reset in the middle of a guard on pad 7.
        f7 = (m_sel[7] == 3) ? 2 : 3;
        drive_data();
        set_cfg(7, f7, 4'b0001);
        tick();
        bus.cfg_valid = 1'b0;
        drive_data();
        mid();
        chk("g7_parked", 256'(bus.pad_oe[7] | bus.pad_ie[7]), 256'(0));
        adv();
        rst = 1'b1;
        drive_data();
        tick();
        rst = 1'b0;
        measure_settle("midreset");
        repeat (4) begin
            drive_data();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
